// File: rtl/power_ups_pkg.sv
// Shared power-up definitions: collect FSM states, screen geometry,
// default overlap threshold and a saturating helper for event counters.
package power_ups_pkg;

  typedef enum logic [0:0] {
    S_READY    = 1'b0,
    S_COOLDOWN = 1'b1
  } collect_state_t;

  localparam int FRAME_W                    = 640;
  localparam int FRAME_H                    = 480;
  localparam int DEFAULT_MIN_OVERLAP_PIXELS = 4;
  localparam int LOST_W                     = 8;

  function automatic logic [LOST_W-1:0] sat_inc_lost(input logic [LOST_W-1:0] value);
    if (value == {LOST_W{1'b1}}) begin
      return value;
    end else begin
      return value + LOST_W'(32'd1);
    end
  endfunction

endpackage

// File: rtl/hoop_collision_arbiter_if.sv
// Signal bundle between the object drawers, hoop mover, score logic and
// the hoop collision arbiter; master is the arbiter side.
interface hoop_collision_arbiter_if;
  import power_ups_pkg::*;

  logic              startOfFrame;
  logic              pause;
  logic              hoopDrawingRequest;
  logic              towerDrawingRequest;
  logic              playerDrawingRequest;
  logic              towerHoopCollision;
  logic              playerHoopCollision;
  logic              collectValid;
  logic              collectReady;
  logic [LOST_W-1:0] lostCollects;

  modport master (
    input  startOfFrame, pause, hoopDrawingRequest, towerDrawingRequest,
           playerDrawingRequest, collectReady,
    output towerHoopCollision, playerHoopCollision, collectValid, lostCollects
  );

  modport slave (
    output startOfFrame, pause, hoopDrawingRequest, towerDrawingRequest,
           playerDrawingRequest, collectReady,
    input  towerHoopCollision, playerHoopCollision, collectValid, lostCollects
  );

endinterface

// File: rtl/overlap_frame_counter.sv
// Saturating per-frame overlap pixel counter with a registered flag telling
// whether the running count has reached the collision threshold.
module overlap_frame_counter #(
  parameter int CNT_W       = 16,
  parameter int MIN_OVERLAP = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic             hit,
  output logic [CNT_W-1:0] count,
  output logic             qualifies
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_OVERLAP);

  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] count_q;
  logic             qual_d;
  logic             qual_q;

  // Next count and threshold flag; the flag tracks count_d so it is current
  // in the frame-close cycle.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = {CNT_W{1'b0}};
    end else if (enable && hit && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_ONE;
    end else begin
      count_d = count_q;
    end
    qual_d = (count_d >= MIN_CNT);
  end

  // Count and threshold registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= {CNT_W{1'b0}};
      qual_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      qual_q  <= qual_d;
    end
  end

  assign count     = count_q;
  assign qualifies = qual_q;

endmodule

// File: rtl/hoop_collision_arbiter.sv
// Per-frame hoop/tower and hoop/player collision pulses, plus a debounced
// once-per-pass collect event delivered over a valid/ready handshake.
module hoop_collision_arbiter
  import power_ups_pkg::*;
#(
  parameter int MIN_OVERLAP_PIXELS = DEFAULT_MIN_OVERLAP_PIXELS,
  parameter int COOLDOWN_FRAMES    = 30,
  parameter int CNT_W              = 16
) (
  input logic                      clk,
  input logic                      reset,
  hoop_collision_arbiter_if.master bus
);

  localparam int              CD_W    = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
  localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN_FRAMES);
  localparam logic [CD_W-1:0] CD_ONE  = CD_W'(32'd1);
  localparam logic [CD_W-1:0] CD_ZERO = {CD_W{1'b0}};

  logic             count_enable_s;
  logic             frame_tick_s;
  logic             tower_hit_s;
  logic             player_hit_s;
  logic             tower_qual_s;
  logic             player_qual_s;
  logic             tower_coll_s;
  logic             player_coll_s;
  logic             raise_s;
  logic [CNT_W-1:0] tower_count_unused;
  logic [CNT_W-1:0] player_count_unused;

  collect_state_t    state_d;
  collect_state_t    state_q;
  logic [CD_W-1:0]   cooldown_d;
  logic [CD_W-1:0]   cooldown_q;
  logic              valid_d;
  logic              valid_q;
  logic [LOST_W-1:0] lost_d;
  logic [LOST_W-1:0] lost_q;

  assign count_enable_s = ~bus.startOfFrame & ~bus.pause;
  assign frame_tick_s   = bus.startOfFrame & ~bus.pause;
  assign tower_hit_s    = bus.hoopDrawingRequest & bus.towerDrawingRequest;
  assign player_hit_s   = bus.hoopDrawingRequest & bus.playerDrawingRequest;

  overlap_frame_counter #(
    .CNT_W       (CNT_W),
    .MIN_OVERLAP (MIN_OVERLAP_PIXELS)
  ) u_tower_cnt (
    .clk       (clk),
    .reset     (reset),
    .enable    (count_enable_s),
    .clear     (bus.startOfFrame),
    .hit       (tower_hit_s),
    .count     (tower_count_unused),
    .qualifies (tower_qual_s)
  );

  overlap_frame_counter #(
    .CNT_W       (CNT_W),
    .MIN_OVERLAP (MIN_OVERLAP_PIXELS)
  ) u_player_cnt (
    .clk       (clk),
    .reset     (reset),
    .enable    (count_enable_s),
    .clear     (bus.startOfFrame),
    .hit       (player_hit_s),
    .count     (player_count_unused),
    .qualifies (player_qual_s)
  );

  // The mover samples these in the startOfFrame cycle itself, so they stay combinational.
  assign tower_coll_s  = frame_tick_s & tower_qual_s & ~reset;
  assign player_coll_s = frame_tick_s & player_qual_s & ~reset;

  // Collect FSM: raise on a player collision when ready, then count down frames.
  always_comb begin
    state_d    = state_q;
    cooldown_d = cooldown_q;
    raise_s    = 1'b0;
    case (state_q)
      S_READY: begin
        if (player_coll_s) begin
          raise_s    = 1'b1;
          cooldown_d = CD_LOAD;
          state_d    = S_COOLDOWN;
        end else begin
          state_d = S_READY;
        end
      end
      S_COOLDOWN: begin
        if (frame_tick_s) begin
          if (cooldown_q <= CD_ONE) begin
            cooldown_d = CD_ZERO;
            state_d    = S_READY;
          end else begin
            cooldown_d = cooldown_q - CD_ONE;
            state_d    = S_COOLDOWN;
          end
        end else begin
          state_d = S_COOLDOWN;
        end
      end
      default: begin
        cooldown_d = CD_ZERO;
        state_d    = S_READY;
      end
    endcase
  end

  // Pending flag and lost counter; a raise coinciding with a handshake replaces the event.
  always_comb begin
    valid_d = valid_q;
    lost_d  = lost_q;
    if (raise_s) begin
      valid_d = 1'b1;
      if (valid_q && !bus.collectReady) begin
        lost_d = sat_inc_lost(lost_q);
      end else begin
        lost_d = lost_q;
      end
    end else if (valid_q && bus.collectReady) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // State, cooldown and handshake registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_READY;
      cooldown_q <= CD_ZERO;
      valid_q    <= 1'b0;
      lost_q     <= {LOST_W{1'b0}};
    end else begin
      state_q    <= state_d;
      cooldown_q <= cooldown_d;
      valid_q    <= valid_d;
      lost_q     <= lost_d;
    end
  end

  assign bus.towerHoopCollision  = tower_coll_s;
  assign bus.playerHoopCollision = player_coll_s;
  assign bus.collectValid        = valid_q;
  assign bus.lostCollects        = lost_q;

endmodule

// File: tb/tb_hoop_collision_arbiter.sv
// Self-checking bench for hoop_collision_arbiter: frame-level vector table,
// hand-written cooldown/handshake/pause/reset sequences and random traffic.
module tb_hoop_collision_arbiter;

  localparam int CD    = 3;
  localparam int MINPX = 4;

  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  hoop_collision_arbiter_if bus();

  hoop_collision_arbiter #(
    .MIN_OVERLAP_PIXELS (MINPX),
    .COOLDOWN_FRAMES    (CD),
    .CNT_W              (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pixel tallies of the open frame, frames of cooldown
  // still to elapse (0 means a collect may be raised), pending flag, losses.
  int m_tower  = 0;
  int m_player = 0;
  int m_cd     = 0;
  int m_lost   = 0;
  bit m_pend   = 1'b0;

  bit last_t;
  bit last_p;

  typedef struct {
    int nt;
    int np;
    bit sof_ovl;
    bit exp_t;
    bit exp_p;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input bit sof, input bit pa, input bit h, input bit t,
                      input bit p, input bit rdy, input bit rst);
    bit exp_t;
    bit exp_p;
    bit raise;
    reset                    = rst;
    bus.startOfFrame         = sof;
    bus.pause                = pa;
    bus.hoopDrawingRequest   = h;
    bus.towerDrawingRequest  = t;
    bus.playerDrawingRequest = p;
    bus.collectReady         = rdy;
    #2;
    exp_t = !rst && sof && !pa && (m_tower >= MINPX);
    exp_p = !rst && sof && !pa && (m_player >= MINPX);
    check("towerHoopCollision", int'(bus.towerHoopCollision), int'(exp_t));
    check("playerHoopCollision", int'(bus.playerHoopCollision), int'(exp_p));
    last_t = bus.towerHoopCollision;
    last_p = bus.playerHoopCollision;
    if (rst) begin
      m_tower = 0; m_player = 0; m_cd = 0; m_lost = 0; m_pend = 1'b0;
    end else begin
      raise = exp_p && (m_cd == 0);
      if (raise) begin
        if (m_pend && !rdy) m_lost = (m_lost < 255) ? m_lost + 1 : 255;
        m_pend = 1'b1;
      end else if (m_pend && rdy) begin
        m_pend = 1'b0;
      end
      if (sof) begin
        if (!pa && m_cd > 0) m_cd--;
        if (raise) m_cd = CD;
        m_tower  = 0;
        m_player = 0;
      end else if (!pa) begin
        if (h && t) m_tower++;
        if (h && p) m_player++;
      end
    end
    @(posedge clk);
    #1;
    check("collectValid", int'(bus.collectValid), int'(m_pend));
    check("lostCollects", int'(bus.lostCollects), m_lost);
  endtask

  task automatic frame(input int nt, input int np, input bit sof_ovl,
                       input bit px_pause, input bit sof_pause,
                       input bit rdy, input bit sof_rdy,
                       output bit got_t, output bit got_p, output bit got_v);
    for (int i = 0; i < 12; i++) begin
      step(1'b0, px_pause, (i < nt) || (i < np), i < nt, i < np, rdy, 1'b0);
    end
    step(1'b1, sof_pause, sof_ovl, sof_ovl, sof_ovl, sof_rdy, 1'b0);
    got_t = last_t;
    got_p = last_p;
    got_v = bus.collectValid;
  endtask

  initial begin
    bit gt;
    bit gp;
    bit gv;
    bit exp_cool[6];
    bit exp_pause[4];
    bit rnd_pause;
    int sof_cnt;

    vecs[0] = '{10, 0, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{ 0, 0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{ 3, 0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{ 4, 0, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{ 3, 0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{ 3, 0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{ 0, 4, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{ 5, 5, 1'b0, 1'b1, 1'b1};
    vecs[8] = '{ 0, 0, 1'b0, 1'b0, 1'b0};
    exp_cool  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    exp_pause = '{1'b0, 1'b0, 1'b0, 1'b1};

    reset = 1'b1;
    bus.startOfFrame = 1'b0; bus.pause = 1'b0; bus.hoopDrawingRequest = 1'b0;
    bus.towerDrawingRequest = 1'b0; bus.playerDrawingRequest = 1'b0;
    bus.collectReady = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("reset collectValid", int'(bus.collectValid), 0);
    check("reset lostCollects", int'(bus.lostCollects), 0);

    // Frame-level vector table.
    for (int i = 0; i < 9; i++) begin
      frame(vecs[i].nt, vecs[i].np, vecs[i].sof_ovl, 1'b0, 1'b0, 1'b1, 1'b1, gt, gp, gv);
      check($sformatf("vec%0d tower pulse", i), int'(gt), int'(vecs[i].exp_t));
      check($sformatf("vec%0d player pulse", i), int'(gp), int'(vecs[i].exp_p));
    end

    // Cooldown: player overlap every frame, events in frames 1 and 5.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int f = 0; f < 6; f++) begin
      frame(0, 5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, gt, gp, gv);
      check($sformatf("cooldown frame%0d event", f + 1), int'(gv), int'(exp_cool[f]));
    end

    // Handshake stalled for 5 frames with two collects.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int f = 0; f < 5; f++) frame(0, 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, gt, gp, gv);
    check("stall collectValid", int'(bus.collectValid), 1);
    check("stall lostCollects", int'(bus.lostCollects), 1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("accept drops collectValid", int'(bus.collectValid), 0);
    check("accept keeps lostCollects", int'(bus.lostCollects), 1);

    // Raise in the same cycle as a completing handshake loses nothing.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int f = 0; f < 4; f++) frame(0, 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, gt, gp, gv);
    frame(0, 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, gt, gp, gv);
    check("same-cycle collectValid", int'(gv), 1);
    check("same-cycle lostCollects", int'(bus.lostCollects), 0);

    // Pause freezes cooldown and suppresses pulses.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    frame(0, 5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, gt, gp, gv);
    check("pause pre-collect", int'(gv), 1);
    frame(6, 6, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, gt, gp, gv);
    check("paused tower pulse", int'(gt), 0);
    check("paused player pulse", int'(gp), 0);
    for (int f = 0; f < 4; f++) begin
      frame(0, 5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, gt, gp, gv);
      check($sformatf("post-pause frame%0d event", f + 1), int'(gv), int'(exp_pause[f]));
    end
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("paused pixels not counted", int'(last_t), 0);
    frame(5, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, gt, gp, gv);
    check("paused sof no pulse", int'(gt), 0);
    frame(2, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, gt, gp, gv);
    check("paused sof clears count", int'(gt), 0);
    frame(4, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, gt, gp, gv);
    check("resumed counting", int'(gt), 1);

    // Reset in the middle of a frame with 50 overlap pixels pending.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int f = 0; f < 5; f++) frame(0, 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, gt, gp, gv);
    for (int i = 0; i < 50; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    check("mid-frame reset collectValid", int'(bus.collectValid), 0);
    check("mid-frame reset lostCollects", int'(bus.lostCollects), 0);
    frame(2, 2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, gt, gp, gv);
    check("post-reset tower pulse", int'(gt), 0);
    check("post-reset player pulse", int'(gp), 0);
    frame(0, 4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, gt, gp, gv);
    check("post-reset player pulse 4px", int'(gp), 1);
    check("post-reset ready to collect", int'(gv), 1);

    // Random traffic against the reference model.
    rnd_pause = 1'b0;
    sof_cnt   = 10;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 15) == 0) rnd_pause = !rnd_pause;
      sof_cnt--;
      step(sof_cnt == 0, rnd_pause, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, $urandom_range(0, 999) == 0);
      if (sof_cnt == 0) sof_cnt = int'($urandom_range(6, 20));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hoop_collision_arbiter.md
Name: hoop_collision_arbiter

Overview:
- Pixel-scan collision detector for the falling hoop power-up. It produces the per-frame tower-hoop collision pulse that the hoop mover samples on startOfFrame.
- It also produces a debounced, once-per-pass "hoop collected" event for the player, delivered to the score logic over a valid/ready handshake.
- Sits between the drawing-request outputs of the object drawers and the hoop mover and score blocks.

Parameters:
- MIN_OVERLAP_PIXELS, 4: overlapping pixels needed in one frame before a collision is reported (filters edge noise).
- COOLDOWN_FRAMES, 30: frames during which further player-hoop collects are suppressed after a collect.
- CNT_W, 16: width of the per-frame overlap pixel counters (saturating).

Ports:
- clk  in  1  system clock (pixel clock domain).
- reset  in  1  synchronous, active-high reset.
- startOfFrame  in  1  one-cycle frame boundary strobe.
- pause  in  1  game paused; freezes detection and cooldown.
- hoopDrawingRequest  in  1  hoop drawer owns the current pixel.
- towerDrawingRequest  in  1  tower drawer owns the current pixel.
- playerDrawingRequest  in  1  player drawer owns the current pixel.
- towerHoopCollision  out  1  high only during a startOfFrame cycle, when the previous frame had a qualifying hoop/tower overlap.
- playerHoopCollision  out  1  same timing, for hoop/player overlap (raw, not debounced).
- collectValid  out  1  collect event pending toward score logic.
- collectReady  in  1  score logic accepts the event.
- lostCollects  out  8  saturating count of collects that arrived while one was already pending.

Behaviour:
- Reset (synchronous, active-high):
  - Both overlap counters = 0.
  - towerHoopCollision = 0, playerHoopCollision = 0, collectValid = 0, lostCollects = 0.
  - FSM = S_READY, cooldown counter = 0.
  - A reset asserted mid-frame discards the partial frame.
- Per-pixel accumulation, every cycle with pause = 0 and startOfFrame = 0:
  - towerCnt increments when hoopDrawingRequest and towerDrawingRequest are both high.
  - playerCnt increments when hoopDrawingRequest and playerDrawingRequest are both high.
  - Both counters saturate at 2^CNT_W - 1.
- Frame close, on a cycle with startOfFrame = 1:
  - towerHoopCollision = (towerCnt >= MIN_OVERLAP_PIXELS) and not pause. It is a combinational AND of startOfFrame with the registered comparison, so the mover sees it in the same cycle.
  - playerHoopCollision is formed the same way from playerCnt.
  - Both counters clear at the clock edge ending this cycle.
  - Overlap pixels in the startOfFrame cycle itself are not counted.
  - Both outputs are 0 in every cycle without startOfFrame.
- pause = 1:
  - Counters hold.
  - Outputs stay 0 even on startOfFrame, but the counters still clear on startOfFrame.
  - The cooldown counter holds.
  - The handshake continues normally.
- Collect FSM:
  - S_READY: on a startOfFrame with playerHoopCollision = 1, raise a collect event, load cooldown = COOLDOWN_FRAMES and go to S_COOLDOWN.
  - S_COOLDOWN: decrement cooldown on each unpaused startOfFrame. Return to S_READY on the startOfFrame where cooldown reaches 0. Player collisions are ignored in this state.
  - A collect in the same startOfFrame that ends cooldown is not raised; the next frame is the first one eligible.
- Collect handshake:
  - A raised event sets collectValid on the next cycle.
  - collectValid holds until a cycle with collectValid = 1 and collectReady = 1, then clears.
  - If a new event is raised while collectValid is already 1, collectValid stays 1 and lostCollects increments, saturating at 255.
  - If the event is raised in the same cycle as a handshake completes, collectValid stays 1 and nothing is lost.

Decomposition:
- Shared package power_ups_pkg holds:
  - typedef collect_state_t {S_READY, S_COOLDOWN}.
  - Constants FRAME_W = 640 and FRAME_H = 480.
  - Default MIN_OVERLAP_PIXELS.
- One sub-module, overlap_frame_counter, instantiated twice (tower, player):
  - Inputs: enable, clear, hit.
  - Output: saturating count and a registered "qualifies" bit.

Test Plan:
- Tower overlap: 10 cycles of hoop & tower in frame N → towerHoopCollision = 1 exactly in the next startOfFrame cycle, 0 elsewhere. Frame N+1 with no overlap → 0.
- Threshold: 3 overlap pixels → no pulse; 4 overlap pixels → pulse. Overlap driven only on the startOfFrame cycle → not counted.
- Cooldown with COOLDOWN_FRAMES = 3 and player overlap every frame:
  - collectValid rises after frame 1.
  - Frames 2–4 raise no event.
  - Frame 5 raises the next event.
- Handshake:
  - collectReady = 0 for 5 frames with two collects → collectValid stays 1 and lostCollects = 1.
  - collectReady = 1 → collectValid drops the next cycle.
- Pause: pause = 1 across a frame with overlaps → no pulses and cooldown holds. Release pause → counting resumes from 0 the next frame.
- Reset mid-frame after 50 overlap pixels → all outputs 0 and FSM = S_READY. The following frame with 2 overlaps gives no pulse.
